// File: rtl/mem_arbiter.sv
// mem_arbiter: DMEM/IMEM arbiter onto one shared memory port, at most one transaction outstanding.
// Define MEM_ARB_STARVE_GUARD_EN to let IMEM win after STARVE_MAX consecutive contested DMEM grants.
module mem_arbiter #(
  parameter int STARVE_MAX = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        imem_req_valid,
  output logic        imem_req_ready,
  input  logic [31:0] imem_req_addr,
  output logic        imem_rsp_valid,
  input  logic        imem_rsp_ready,
  output logic [31:0] imem_rsp_data,
  input  logic        dmem_req_valid,
  output logic        dmem_req_ready,
  input  logic [31:0] dmem_req_addr,
  input  logic [31:0] dmem_req_wdata,
  input  logic [3:0]  dmem_req_wstrb,
  output logic        dmem_rsp_valid,
  input  logic        dmem_rsp_ready,
  output logic [31:0] dmem_rsp_data,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  output logic [31:0] mem_req_wdata,
  output logic [3:0]  mem_req_wstrb,
  input  logic        mem_rsp_valid,
  output logic        mem_rsp_ready,
  input  logic [31:0] mem_rsp_data
);
  localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, RSP = 2'd2;
  logic [1:0]  state;
  logic        owner_d;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  wstrb_q;
  logic        idle, rsp, d_win, grant_d, grant_i;
`ifdef MEM_ARB_STARVE_GUARD_EN
  logic [3:0] starve;
  assign d_win = dmem_req_valid && !(imem_req_valid && starve >= 4'(STARVE_MAX));
  always_ff @(posedge clk or posedge rst)
    if (rst) starve <= '0;
    else if (grant_i) starve <= '0;
    else if (grant_d && imem_req_valid && starve != 4'hf) starve <= starve + 4'd1;
`else
  assign d_win = dmem_req_valid;
`endif
  // readies are masked by rst so nothing is granted while reset is held
  assign idle    = state == IDLE && !rst;
  assign rsp     = state == RSP;
  assign grant_d = idle && d_win;
  assign grant_i = idle && imem_req_valid && !d_win;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state   <= IDLE;
      owner_d <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else if (grant_d || grant_i) begin
      state   <= REQ;
      owner_d <= grant_d;
      addr_q  <= grant_d ? dmem_req_addr : imem_req_addr;
      wdata_q <= grant_d ? dmem_req_wdata : '0;
      wstrb_q <= grant_d ? dmem_req_wstrb : '0;
    end else if (state == REQ && mem_req_ready) begin
      state <= RSP;
    end else if (rsp && mem_rsp_valid && mem_rsp_ready) begin
      state <= IDLE;
    end
  assign imem_req_ready = grant_i;
  assign dmem_req_ready = grant_d;
  assign mem_req_valid  = state == REQ;
  assign mem_req_addr   = addr_q;
  assign mem_req_wdata  = wdata_q;
  assign mem_req_wstrb  = wstrb_q;
  assign mem_rsp_ready  = rsp && (owner_d ? dmem_rsp_ready : imem_rsp_ready);
  assign imem_rsp_valid = rsp && !owner_d && mem_rsp_valid;
  assign dmem_rsp_valid = rsp && owner_d && mem_rsp_valid;
  assign imem_rsp_data  = rsp && !owner_d ? mem_rsp_data : '0;
  assign dmem_rsp_data  = rsp && owner_d ? mem_rsp_data : '0;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter against a transaction-level model.
module tb_mem_arbiter;
  localparam int SMAX = 3;
`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif
  logic        clk = 1'b0, rst = 1'b1;
  logic        imem_req_valid, imem_req_ready, imem_rsp_valid, imem_rsp_ready;
  logic [31:0] imem_req_addr, imem_rsp_data;
  logic        dmem_req_valid, dmem_req_ready, dmem_rsp_valid, dmem_rsp_ready;
  logic [31:0] dmem_req_addr, dmem_req_wdata, dmem_rsp_data;
  logic [3:0]  dmem_req_wstrb;
  logic        mem_req_valid, mem_req_ready, mem_rsp_valid, mem_rsp_ready;
  logic [31:0] mem_req_addr, mem_req_wdata, mem_rsp_data;
  logic [3:0]  mem_req_wstrb;

  mem_arbiter #(.STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_ready(imem_rsp_ready), .imem_rsp_data(imem_rsp_data),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready), .dmem_req_addr(dmem_req_addr),
    .dmem_req_wdata(dmem_req_wdata), .dmem_req_wstrb(dmem_req_wstrb),
    .dmem_rsp_valid(dmem_rsp_valid), .dmem_rsp_ready(dmem_rsp_ready), .dmem_rsp_data(dmem_rsp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready), .mem_rsp_data(mem_rsp_data)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: one pending record, whether it has been issued, and the contested-DMEM streak.
  bit          m_busy, m_issued, m_own_d;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_wstrb;
  int          m_streak;
  int          n_memreq, n_drsp, n_irsp;
  byte         order[$];

  always @(negedge clk) begin : model
    bit dw, iw, ph, own_rdy;
    if (mem_req_valid && mem_req_ready) n_memreq++;
    if (dmem_rsp_valid && dmem_rsp_ready) n_drsp++;
    if (imem_rsp_valid && imem_rsp_ready) n_irsp++;
    if (imem_req_valid && imem_req_ready) order.push_back(8'h49);
    if (dmem_req_valid && dmem_req_ready) order.push_back(8'h44);
    if (rst) begin
      chk("rst_ctl", {imem_req_ready, dmem_req_ready, imem_rsp_valid, dmem_rsp_valid,
                      mem_req_valid, mem_rsp_ready, mem_req_wstrb}, 32'd0);
      chk("rst_addr", mem_req_addr, 32'd0);
      chk("rst_wdata", mem_req_wdata, 32'd0);
      chk("rst_irsp_data", imem_rsp_data, 32'd0);
      chk("rst_drsp_data", dmem_rsp_data, 32'd0);
      m_busy   = 1'b0;
      m_issued = 1'b0;
      m_streak = 0;
    end else begin
      dw = !m_busy && dmem_req_valid && !(GUARD && imem_req_valid && m_streak >= SMAX);
      iw = !m_busy && imem_req_valid && !dw;
      ph = m_busy && m_issued;
      own_rdy = m_own_d ? dmem_rsp_ready : imem_rsp_ready;
      chk("req_ready", {imem_req_ready, dmem_req_ready}, {iw, dw});
      chk("mem_req_valid", mem_req_valid, m_busy && !m_issued);
      if (m_busy && !m_issued) begin
        chk("mem_req_addr", mem_req_addr, m_addr);
        chk("mem_req_wdata", mem_req_wdata, m_wdata);
        chk("mem_req_wstrb", mem_req_wstrb, m_wstrb);
      end
      chk("rsp_route", {imem_rsp_valid, dmem_rsp_valid, mem_rsp_ready},
          {ph && !m_own_d && mem_rsp_valid, ph && m_own_d && mem_rsp_valid, ph && own_rdy});
      if (ph && m_own_d) chk("dmem_rsp_data", dmem_rsp_data, mem_rsp_data);
      if (ph && !m_own_d) chk("imem_rsp_data", imem_rsp_data, mem_rsp_data);
      if (ph && mem_rsp_valid && own_rdy) m_busy = 1'b0;
      else if (m_busy && !m_issued && mem_req_ready) m_issued = 1'b1;
      else if (dw || iw) begin
        m_busy   = 1'b1;
        m_issued = 1'b0;
        m_own_d  = dw;
        m_addr   = dw ? dmem_req_addr : imem_req_addr;
        m_wdata  = dw ? dmem_req_wdata : 32'd0;
        m_wstrb  = dw ? dmem_req_wstrb : 4'd0;
        if (dw && imem_req_valid) m_streak++;
        if (iw) m_streak = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // completes whatever is in flight and leaves the arbiter idle
  task automatic drain();
    imem_req_valid = 1'b0;
    dmem_req_valid = 1'b0;
    mem_req_ready  = 1'b1;
    mem_rsp_valid  = 1'b1;
    imem_rsp_ready = 1'b1;
    dmem_rsp_ready = 1'b1;
    repeat (4) step();
    mem_rsp_valid = 1'b0;
  endtask

  initial begin
    int n0_req, n0_rsp;
    imem_req_valid = 1'b1; imem_req_addr = 32'h0; imem_rsp_ready = 1'b0;
    dmem_req_valid = 1'b1; dmem_req_addr = 32'h0; dmem_req_wdata = 32'h0; dmem_req_wstrb = 4'h0;
    dmem_rsp_ready = 1'b0; mem_req_ready = 1'b1; mem_rsp_valid = 1'b1; mem_rsp_data = 32'hffff_ffff;
    repeat (2) step();
    @(negedge clk);
    chk("reset_ready", {imem_req_ready, dmem_req_ready}, 32'd0);
    chk("reset_rsp_valid", {imem_rsp_valid, dmem_rsp_valid}, 32'd0);

    // lone fetch, accepted in the first cycle after reset
    step(); rst = 1'b0; dmem_req_valid = 1'b0; mem_rsp_valid = 1'b0;
    imem_req_addr = 32'h40; imem_rsp_ready = 1'b1;
    @(negedge clk); chk("t1_accept", imem_req_ready, 1'b1);
    step(); imem_req_valid = 1'b0;
    @(negedge clk); chk("t1_req_valid", mem_req_valid, 1'b1); chk("t1_addr", mem_req_addr, 32'h40);
    step(); mem_rsp_valid = 1'b1; mem_rsp_data = 32'h0050_0093;
    @(negedge clk); chk("t1_rsp_valid", imem_rsp_valid, 1'b1); chk("t1_rsp_data", imem_rsp_data, 32'h0050_0093);
    step(); mem_rsp_valid = 1'b0; imem_req_valid = 1'b1; imem_req_addr = 32'h44;
    @(negedge clk); chk("t1_idle_after3", imem_req_ready, 1'b1);
    step(); drain();

    // simultaneous requests: store wins, fetch follows
    imem_req_valid = 1'b1; imem_req_addr = 32'h0; mem_req_ready = 1'b0;
    dmem_req_valid = 1'b1; dmem_req_addr = 32'h100; dmem_req_wdata = 32'hdead_beef; dmem_req_wstrb = 4'hf;
    @(negedge clk); chk("t2_grant", {imem_req_ready, dmem_req_ready}, 32'd1);
    step(); dmem_req_valid = 1'b0; mem_req_ready = 1'b1;
    @(negedge clk);
    chk("t2_addr", mem_req_addr, 32'h100); chk("t2_wdata", mem_req_wdata, 32'hdead_beef);
    chk("t2_wstrb", mem_req_wstrb, 4'hf); chk("t2_loser_wait", imem_req_ready, 1'b0);
    step(); mem_rsp_valid = 1'b1; mem_rsp_data = 32'h1; dmem_rsp_ready = 1'b1;
    @(negedge clk); chk("t2_drsp", {imem_rsp_valid, dmem_rsp_valid}, 32'd1);
    step(); mem_rsp_valid = 1'b0;
    @(negedge clk); chk("t2_imem_next", imem_req_ready, 1'b1);
    step(); imem_req_valid = 1'b0;
    @(negedge clk); chk("t2_imem_addr", mem_req_addr, 32'h0); chk("t2_imem_wstrb", mem_req_wstrb, 4'h0);
    drain();

    // back-pressure on both request and response
    n0_req = n_memreq; n0_rsp = n_drsp;
    dmem_req_valid = 1'b1; dmem_req_addr = 32'h200; dmem_req_wdata = 32'h0; dmem_req_wstrb = 4'h0;
    mem_req_ready = 1'b0;
    @(negedge clk); chk("t3_accept", dmem_req_ready, 1'b1);
    step(); dmem_req_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t3_hold_valid", mem_req_valid, 1'b1); chk("t3_hold_addr", mem_req_addr, 32'h200);
      step();
    end
    mem_req_ready = 1'b1;
    step(); mem_rsp_valid = 1'b1; mem_rsp_data = 32'h1234_5678; dmem_rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); chk("t3_rsp_hold", {dmem_rsp_valid, mem_rsp_ready}, 32'd2);
      step();
    end
    dmem_rsp_ready = 1'b1;
    @(negedge clk); chk("t3_rsp_data", dmem_rsp_data, 32'h1234_5678);
    step(); mem_rsp_valid = 1'b0;
    repeat (2) step();
    chk("t3_one_request", n_memreq - n0_req, 1);
    chk("t3_one_response", n_drsp - n0_rsp, 1);

    // starvation pattern with both sides always requesting
    rst = 1'b1; step(); rst = 1'b0;
    order.delete();
    imem_req_valid = 1'b1; dmem_req_valid = 1'b1; mem_req_ready = 1'b1; mem_rsp_valid = 1'b1;
    for (int i = 0; i < 60 && order.size() < 8; i++) step();
    chk("t4_grant_count", order.size() >= 8, 1'b1);
    for (int k = 0; k < 8 && k < order.size(); k++)
      chk($sformatf("t4_grant%0d", k), order[k], (GUARD && k % 4 == 3) ? 8'h49 : 8'h44);
    drain();

    // reset while a fetch waits in the response phase
    imem_req_valid = 1'b1; imem_req_addr = 32'h80; mem_req_ready = 1'b1; mem_rsp_valid = 1'b0;
    @(negedge clk); chk("t5_accept", imem_req_ready, 1'b1);
    step(); imem_req_valid = 1'b0;
    step();
    @(negedge clk); chk("t5_in_rsp", mem_rsp_ready, 1'b1);
    n0_rsp = n_irsp;
    step(); rst = 1'b1; mem_rsp_valid = 1'b1; imem_req_valid = 1'b1; dmem_req_valid = 1'b1;
    @(negedge clk); chk("t5_rst_rsp", imem_rsp_valid, 1'b0); chk("t5_rst_req_valid", mem_req_valid, 1'b0);
    step(); rst = 1'b0; dmem_req_valid = 1'b0; mem_rsp_valid = 1'b0;
    @(negedge clk); chk("t5_after_rst_accept", imem_req_ready, 1'b1);
    step(); imem_req_valid = 1'b0;
    chk("t5_aborted", n_irsp - n0_rsp, 0);
    drain();
    chk("t5_next_completes", n_irsp - n0_rsp, 1);

    // randomized traffic with occasional resets
    for (int c = 0; c < 3000; c++) begin
      bit hi, hd;
      @(negedge clk);
      hi = imem_req_valid && imem_req_ready;
      hd = dmem_req_valid && dmem_req_ready;
      step();
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 249) == 0) rst = 1'b1;
      if (hi || !imem_req_valid) begin
        imem_req_valid = 1'($urandom_range(0, 1));
        imem_req_addr  = $urandom;
      end
      if (hd || !dmem_req_valid) begin
        dmem_req_valid = 1'($urandom_range(0, 1));
        dmem_req_addr  = $urandom;
        dmem_req_wdata = $urandom;
        dmem_req_wstrb = 4'($urandom_range(0, 15));
      end
      mem_req_ready  = $urandom_range(0, 3) != 0;
      mem_rsp_valid  = 1'($urandom_range(0, 1));
      mem_rsp_data   = $urandom;
      imem_rsp_ready = 1'($urandom_range(0, 1));
      dmem_rsp_ready = 1'($urandom_range(0, 1));
    end
    rst = 1'b0;
    drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 3, the maximum number of consecutive DMEM grants while IMEM is pending (range 1..15).
REQ-002 SHALL have port clk  in  1  clock; every flop is rising-edge.
REQ-003 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have port imem_req_valid  in  1  fetch request valid.
REQ-005 SHALL have port imem_req_ready  out  1  fetch request accepted.
REQ-006 SHALL have port imem_req_addr  in  32  fetch byte address.
REQ-007 SHALL have port imem_rsp_valid  out  1  fetch data valid.
REQ-008 SHALL have port imem_rsp_ready  in  1  fetch side can take data.
REQ-009 SHALL have port imem_rsp_data  out  32  fetched instruction.
REQ-010 SHALL have port dmem_req_valid  in  1  data request valid.
REQ-011 SHALL have port dmem_req_ready  out  1  data request accepted.
REQ-012 SHALL have port dmem_req_addr  in  32  data byte address.
REQ-013 SHALL have port dmem_req_wdata  in  32  store data.
REQ-014 SHALL have port dmem_req_wstrb  in  4  byte write strobes; 0 means load.
REQ-015 SHALL have port dmem_rsp_valid  out  1  load data or store ack valid.
REQ-016 SHALL have port dmem_rsp_ready  in  1  data side can take the response.
REQ-017 SHALL have port dmem_rsp_data  out  32  load data; undefined for stores.
REQ-018 SHALL have ports mem_req_valid out 1, mem_req_ready in 1, mem_req_addr out 32, mem_req_wdata out 32, mem_req_wstrb out 4, which form the shared memory request port.
REQ-019 SHALL have ports mem_rsp_valid in 1, mem_rsp_ready out 1, mem_rsp_data in 32, which form the shared memory response port.

Function
REQ-020 SHALL use an FSM with states IDLE, REQ and RSP, and SHALL allow at most one transaction outstanding.
REQ-021 IDLE: the arbiter SHALL combinationally grant one valid requester, and SHALL drive ready=1 to that requester only.
REQ-022 Arbitration SHALL give DMEM priority over IMEM by default.
REQ-023 A handshake in IDLE SHALL register the owner, addr, wdata and wstrb (IMEM: wdata=0, wstrb=0) and move to REQ.
REQ-024 REQ: mem_req_valid=1 with the registered fields; when mem_req_ready=1, move to RSP. The request SHALL appear on mem_req one cycle after acceptance.
REQ-025 REQ: all registered fields SHALL be held stable while mem_req_ready=0.
REQ-026 RSP: mem_rsp_valid and mem_rsp_data SHALL pass combinationally to the owner's rsp port. mem_rsp_ready SHALL equal the owner's rsp_ready. The non-owner rsp_valid SHALL be 0.
REQ-027 RSP: a response handshake SHALL move the FSM to IDLE. The earliest next acceptance is the following cycle, so the best-case throughput is one transaction per 3 cycles.
REQ-028 Outside RSP, both rsp_valid outputs and mem_rsp_ready SHALL be 0.
REQ-029 Outside REQ, mem_req_valid SHALL be 0.
REQ-030 Outside IDLE, both req_ready outputs SHALL be 0.
REQ-031 When both requesters are valid in the same cycle, only the winner SHALL be readied; the loser SHALL keep valid high and not be dropped.
REQ-032 A mem_rsp_valid pulse received outside RSP SHALL be ignored.

Reset
REQ-033 While rst=1: state=IDLE, all registered fields=0, starve counter=0, and every output SHALL be 0, including both req_ready outputs.
REQ-034 Assertion of rst mid-transaction SHALL abort the transaction; the owner SHALL receive no response.
REQ-035 The first acceptance SHALL be possible in the first cycle after rst deasserts.

Configuration
REQ-036 Macro MEM_ARB_STARVE_GUARD_EN, when defined, SHALL add a 4-bit starve counter:
- increments on each DMEM grant while imem_req_valid=1;
- clears on each IMEM grant;
- once the counter reaches STARVE_MAX, IMEM SHALL win the next contested arbitration.
REQ-037 Without MEM_ARB_STARVE_GUARD_EN, there SHALL be no counter and strict DMEM priority SHALL apply.

Verification
REQ-038 Lone IMEM request: imem addr=0x40, mem_req_ready=1, mem returns 0x00500093 next cycle -> mem_req_valid one cycle after acceptance with addr 0x40; imem_rsp_data=0x00500093; back in IDLE 3 cycles after acceptance.
REQ-039 Simultaneous requests, IMEM addr 0x0 and DMEM store addr 0x100/wdata 0xDEADBEEF/wstrb 0xF -> DMEM served first with exact fields; IMEM accepted in the first IDLE afterwards.
REQ-040 Back-pressure: mem_req_ready=0 for 5 cycles and dmem_rsp_ready=0 for 3 cycles -> fields stable throughout; no duplicate requests; exactly one response.
REQ-041 MEM_ARB_STARVE_GUARD_EN defined, STARVE_MAX=3, both requesters continuously valid -> grant order D,D,D,I repeating. Without the macro -> DMEM only.
REQ-042 rst pulsed while in RSP -> no rsp_valid to the owner; all outputs 0; the next request completes normally.
